// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply engine.
//   mm_state_e : control FSM states (IDLE / LOAD / OUT)
//   DEF_*      : default parameter values for the engine and its cells
//   MAX_W      : internal arithmetic width for accumulator sums (ACC_W <= MAX_W-1)
//   fit_acc    : reduces a wide sum to ACC_W bits by saturation or wrap, flagging overflow
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    OUT
  } mm_state_e;

  localparam int unsigned DEF_M     = 4;
  localparam int unsigned DEF_N     = 4;
  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_ACC_W = 32;
  localparam int unsigned DEF_KW    = 8;
  localparam int unsigned DEF_SAT   = 1;
  localparam int unsigned MAX_W     = 64;

  // The result is returned sign-extended to MAX_W; callers keep the low acc_w bits.
  function automatic logic signed [MAX_W-1:0] fit_acc(
    input  logic signed [MAX_W-1:0] sum,
    input  int unsigned             acc_w,
    input  logic                    sat,
    output logic                    ovf
  );
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic signed [MAX_W-1:0] wrapped;
    hi      = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (acc_w - 1));
    wrapped = (sum <<< (MAX_W - acc_w)) >>> (MAX_W - acc_w);
    ovf     = 1'b0;
    if (sat) begin
      if (sum > hi) begin
        fit_acc = hi;
        ovf     = 1'b1;
      end else if (sum < lo) begin
        fit_acc = lo;
        ovf     = 1'b1;
      end else begin
        fit_acc = sum;
      end
    end else begin
      fit_acc = wrapped;
      ovf     = (wrapped != sum);
    end
  endfunction

endpackage

// File: rtl/matrix_mult_engine_mac_pe.sv
// One signed multiply-accumulate cell of the outer-product array.
//   clk, reset : clock, async active-high reset (accumulator -> 0)
//   clr_i      : clear the accumulator (wins over en_i)
//   en_i       : add a_i*b_i into the accumulator; otherwise hold
//   a_i, b_i   : signed DW-bit operands
//   acc_o      : accumulator contents
//   ovf_o      : this cycle's update saturated or wrapped (only while en_i)
module mac_pe
  import mm_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned SAT   = DEF_SAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic signed [DW-1:0]  a_i,
  input  logic signed [DW-1:0]  b_i,
  output logic [ACC_W-1:0]      acc_o,
  output logic                  ovf_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DW-1:0]  prod;
  logic signed [MAX_W-1:0] sum;
  logic                    of;

  assign prod  = a_i * b_i;
  assign acc_o = acc_q;

  always_comb begin
    sum   = MAX_W'(acc_q) + MAX_W'(prod);
    acc_d = acc_q;
    of    = 1'b0;
    ovf_o = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = ACC_W'(fit_acc(sum, ACC_W, SAT != 0, of));
      ovf_o = of;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/matrix_mult_engine.sv
// Streaming matrix-multiply engine: C[M][N] = A[M][K] x B[K][N] built from K
// rank-1 updates, one A column and one B row per accepted beat.
//   clk, reset           : clock, async active-high reset
//   start, k_len,
//   accumulate           : tile setup, sampled in IDLE only
//   busy                 : not IDLE
//   in_valid/in_ready    : operand beat handshake (a_col, b_row)
//   out_valid/out_ready  : result tile handshake (c_out, ovf)
//   ovf                  : sticky per tile; some cell saturated or wrapped
module matrix_mult_engine
  import mm_pkg::*;
#(
  parameter int unsigned M     = DEF_M,
  parameter int unsigned N     = DEF_N,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned KW    = DEF_KW,
  parameter int unsigned SAT   = DEF_SAT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   accumulate,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M*DW-1:0]        a_col,
  input  logic [N*DW-1:0]        b_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M*N*ACC_W-1:0]   c_out,
  output logic                   ovf
);

  mm_state_e     state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] klen_q, klen_d;
  logic          ovf_q, ovf_d;
  logic          clr, en;
  logic [M*N-1:0] cell_ovf;

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == OUT);
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    ovf_d   = ovf_q | (|cell_ovf);
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          klen_d  = k_len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          clr     = !accumulate;
          state_d = (k_len != '0) ? LOAD : OUT;
        end
      end
      LOAD: begin
        if (in_valid) begin
          en    = 1'b1;
          cnt_d = cnt_q + KW'(1);
          if (cnt_d == klen_q) state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      mac_pe #(
        .DW    (DW),
        .ACC_W (ACC_W),
        .SAT   (SAT)
      ) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr),
        .en_i  (en),
        .a_i   (a_col[i*DW +: DW]),
        .b_i   (b_row[j*DW +: DW]),
        .acc_o (c_out[(i*N+j)*ACC_W +: ACC_W]),
        .ovf_o (cell_ovf[i*N+j])
      );
    end
  end

endmodule
